// File: rtl/bf_cell_alu_pipe.sv
// bf_cell_alu_pipe: two-stage valid/ready cell ALU for the BeeF tape path.
// Performs a signed multi-step ADD (wrap or saturate), CLR or PASS, and reports zero/overflow flags.
`timescale 1ns/1ps
module bf_cell_alu_pipe #(
   parameter int WIDTH   = 8,
   parameter int DELTA_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [1:0]         op_i,
   input  logic               sat_i,
   input  logic [WIDTH-1:0]   data_i,
   input  logic [DELTA_W-1:0] delta_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [WIDTH-1:0]   result_o,
   output logic               zero_o,
   output logic               ovf_o
);
   localparam int SW = (WIDTH > DELTA_W ? WIDTH : DELTA_W) + 2;
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_CLR = 2'b01;

   logic               s1_valid_q, s1_valid_d, s1_sat_q, s1_sat_d;
   logic [1:0]         s1_op_q, s1_op_d;
   logic [WIDTH-1:0]   s1_data_q, s1_data_d;
   logic [DELTA_W-1:0] s1_delta_q, s1_delta_d;
   logic               s2_valid_q, s2_valid_d, zero_q, zero_d, ovf_q, ovf_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic               in_xfer, out_xfer, s1_move, under, over;
   logic [SW-1:0]      sum;
   logic [WIDTH-1:0]   add_res, alu_res;

   always_comb begin
      out_xfer   = s2_valid_q & out_ready_i;
      s1_move    = s1_valid_q & (!s2_valid_q | out_ready_i);
      in_ready_o = !s1_valid_q | s1_move;
      in_xfer    = in_valid_i & in_ready_o;
      // Sum is formed wide enough that negative and above-max results are both distinguishable
      sum     = {{(SW-WIDTH){1'b0}}, s1_data_q} + {{(SW-DELTA_W){s1_delta_q[DELTA_W-1]}}, s1_delta_q};
      under   = sum[SW-1];
      over    = !under & (|sum[SW-2:WIDTH]);
      add_res = !s1_sat_q ? sum[WIDTH-1:0] : under ? '0 : over ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
      alu_res = s1_op_q == OP_ADD ? add_res : s1_op_q == OP_CLR ? '0 : s1_data_q;
      s1_valid_d = in_xfer ? 1'b1 : s1_move ? 1'b0 : s1_valid_q;
      s1_op_d    = in_xfer ? op_i : s1_op_q;
      s1_sat_d   = in_xfer ? sat_i : s1_sat_q;
      s1_data_d  = in_xfer ? data_i : s1_data_q;
      s1_delta_d = in_xfer ? delta_i : s1_delta_q;
      s2_valid_d = s1_move ? 1'b1 : out_xfer ? 1'b0 : s2_valid_q;
      res_d      = s1_move ? alu_res : res_q;
      zero_d     = s1_move ? (alu_res == '0) : zero_q;
      ovf_d      = s1_move ? ((s1_op_q == OP_ADD) & (under | over)) : ovf_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_op_q    <= '0;
         s1_sat_q   <= 1'b0;
         s1_data_q  <= '0;
         s1_delta_q <= '0;
         s2_valid_q <= 1'b0;
         res_q      <= '0;
         zero_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_op_q    <= s1_op_d;
         s1_sat_q   <= s1_sat_d;
         s1_data_q  <= s1_data_d;
         s1_delta_q <= s1_delta_d;
         s2_valid_q <= s2_valid_d;
         res_q      <= res_d;
         zero_q     <= zero_d;
         ovf_q      <= ovf_d;
      end
   end

   assign out_valid_o = s2_valid_q;
   assign result_o    = res_q;
   assign zero_o      = zero_q;
   assign ovf_o       = ovf_q;
endmodule
